ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/mips_pkg.sv | 21 ++
 rtl/inst_fifo.sv | 60 ++++++
 rtl/ifetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared core constants and types: word geometry, default reset vector and
// the {pc, inst} entry carried through the fetch buffer.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int INST_BYTES = 4;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_W'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction buffer with first-word fall-through read and a
// single-cycle clear that empties it on a fetch redirect.
module inst_fifo
    import mips_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

`ifndef SYNTHESIS
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !pop && !clear) |-> (count != CNT_W'(DEPTH)));
    no_underflow: assert property (@(posedge clk) disable iff (rst)
        (pop && !clear) |-> (count != '0));
`endif

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited in-order requests to instruction memory,
// buffered responses tagged with their PC, and redirect with stale-response drop.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit;
    logic              grant;
    logic              push;
    logic              pop;
    logic              dropping;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Every in-flight request, even one destined to be discarded, holds a
    // buffer slot, so the buffer can never be overrun by returning data.
    assign credit    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = !rst && !redirect && (credit < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign dropping   = (discard != '0);
    assign push       = imem_rvalid && !redirect && !dropping;
    assign inst_valid = (fifo_count != '0);
    assign pop        = inst_valid && inst_ready && !redirect;
    assign push_entry = '{pc: resp_pc, inst: imem_rdata};
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case ({grant, imem_rvalid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect) begin
                fetch_pc <= word_align(redirect_pc);
                resp_pc  <= word_align(redirect_pc);
                // A response landing in this very cycle is already dropped.
                discard  <= outstanding - CW'(imem_rvalid);
            end else begin
                if (grant)                    fetch_pc <= fetch_pc + WORD_W'(INST_BYTES);
                if (push)                     resp_pc  <= resp_pc + WORD_W'(INST_BYTES);
                if (imem_rvalid && dropping)  discard  <= discard - CW'(1);
            end
        end
    end

    inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .count (fifo_count)
    );

`ifndef SYNTHESIS
    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outstanding != '0));
`endif

endmodule
